alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised successor to the single-cycle integer ALU.
- Adds the RV32M/RV64M multiply/divide ops through a sequential shift-add multiplier and a restoring divider.
- Uses valid/ready handshakes on both sides so the execute stage can stall on multi-cycle ops.
- Sits in the EX stage; base ops still complete with fixed 1-cycle latency.

Parameters:
- XLEN, 32, datapath width; a power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; drops the in-flight op.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op.
- a  in  XLEN  operand A (dividend, multiplicand).
- b  in  XLEN  operand B (divisor, multiplier).
- alu_op  in  5  operation code.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  result.

Behaviour:
- Op codes:
  - 0x00-0x0A: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, EQ.
  - 0x10-0x17: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Any other code: result 0, 1-cycle latency.
- Shifts use b[SHW-1:0]. SLT/SLTU/EQ return 1 or 0, zero-extended. All arithmetic wraps modulo 2^XLEN.
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE, with out_valid=0, result=0, and all internal registers 0.
- in_ready = (state==IDLE). An op is accepted on in_valid && in_ready. Operands are captured at acceptance; a, b and alu_op are don't-care afterwards.
- IDLE, on accept:
  - Base op: result computed and registered, go to DONE. out_valid rises the next cycle (latency 1).
  - MUL*: load magnitudes and sign flags, counter=0, go to MUL.
  - DIV* with a normal divisor: same setup, go to DIV.
  - DIV* fast path, go straight to DONE with latency 1:
    - b==0: DIV/DIVU give all-ones; REM/REMU give a.
    - Signed overflow (a==MIN, b==-1): DIV gives MIN; REM gives 0.
- MUL state:
  - One partial-product bit per cycle into a 2*XLEN accumulator, on operand magnitudes.
  - After XLEN cycles: apply the sign correction, select the low half (MUL) or high half (MULH/MULHSU/MULHU), go to DONE.
  - out_valid rises XLEN+1 cycles after acceptance.
  - Signedness: MULH treats a and b as signed; MULHSU treats a signed, b unsigned; MULHU and MUL treat both as unsigned.
- DIV state:
  - Restoring division on magnitudes, one quotient bit per cycle, XLEN cycles.
  - Quotient sign = sign(a) XOR sign(b), signed ops only.
  - Remainder sign = sign(a), signed ops only.
  - Go to DONE; latency XLEN+1.
- DONE:
  - out_valid=1 and result held stable until out_ready.
  - On out_valid && out_ready: go to IDLE, out_valid=0 the next cycle.
  - No new op is accepted in the same cycle as the handoff; minimum issue interval is 2 cycles.
- flush:
  - Has priority over every other event in any state.
  - Next state IDLE, out_valid=0, counter cleared, result unchanged.
  - An in_valid presented in the same cycle as flush is not accepted.
- Async rst mid-operation: immediate return to the reset state; no partial result is ever presented.
- Backpressure: out_ready low holds DONE indefinitely, with result stable and in_ready=0.

Test Plan (XLEN=32):
- Base ops:
  - ADD a=0xFFFFFFFF, b=1 -> result 0x00000000 one cycle after accept.
  - SRA a=0x80000000, b=0x24 (shamt 4) -> 0xF8000000.
  - SLT a=0xFFFFFFFF, b=0 -> 1; SLTU with the same operands -> 0.
- Multiply:
  - MUL a=7, b=-3 -> 0xFFFFFFEB.
  - MULH a=0x80000000, b=0x80000000 -> 0x40000000.
  - MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
  - Every multiply has out_valid exactly 33 cycles after accept.
- Divide:
  - DIV a=-7, b=2 -> -3 (0xFFFFFFFD); REM with the same operands -> -1.
  - DIVU a=100, b=7 -> 14; REMU with the same operands -> 2.
  - Latency is 33 cycles for each.
- Divide corner cases, all with latency 1:
  - DIVU a=5, b=0 -> 0xFFFFFFFF.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - Hold out_ready=0 for 10 cycles after a MUL completes -> result stable, in_ready=0 throughout.
  - Raise out_ready -> out_valid drops next cycle and in_ready returns.
- Abort:
  - flush asserted at cycle 10 of a DIV -> IDLE next cycle, out_valid never asserted.
  - rst pulsed mid-MUL -> outputs 0 immediately.
  - A new ADD issued afterwards completes correctly with latency 1.

Source files
------------

// File: rtl/alu_iter.sv
// EX-stage integer ALU: 1-cycle base ops, iterative RV32M/RV64M mul/div.
// Ports: clk, rst (async), flush, in_valid/in_ready, a, b, alu_op,
//        out_valid/out_ready, result.
module alu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      alu_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t            state;
  logic [2*XLEN-1:0] p;
  logic [XLEN-1:0]   d;
  logic [2:0]        mop;
  logic              nega;
  logic              negb;
  logic [SHW-1:0]    cnt;

  assign in_ready = (state == IDLE);

  // ---- base ops and operand preparation ----
  logic [SHW-1:0]  sh;
  logic [XLEN-1:0] base;
  logic [2:0]      m;
  logic            is_m;
  logic            is_div;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            bz;
  logic            ovf;
  logic [XLEN-1:0] fast;

  assign sh     = b[SHW-1:0];
  assign m      = alu_op[2:0];
  assign is_m   = (alu_op[4:3] == 2'b10);
  assign is_div = is_m && m[2];

  // signed a: MULH, MULHSU, DIV, REM; signed b: MULH, DIV, REM
  assign sa = a[XLEN-1] &&
              (m == 3'd1 || m == 3'd2 || m == 3'd4 || m == 3'd6);
  assign sb = b[XLEN-1] &&
              (m == 3'd1 || m == 3'd4 || m == 3'd6);

  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign bz  = (b == '0);
  assign ovf = (m == 3'd4 || m == 3'd6) && (a == SMIN) && (b == '1);

  // m[1] set means a remainder op
  always_comb begin
    fast = '0;
    if (bz)
      fast = m[1] ? a : '1;
    else if (ovf)
      fast = m[1] ? '0 : SMIN;
  end

  always_comb begin
    base = '0;
    case (alu_op)
      5'h00: base = a + b;
      5'h01: base = a - b;
      5'h02: base = a & b;
      5'h03: base = a | b;
      5'h04: base = a ^ b;
      5'h05: base = a << sh;
      5'h06: base = a >> sh;
      5'h07: base = $signed(a) >>> sh;
      5'h08: base = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      5'h09: base = {{(XLEN-1){1'b0}}, a < b};
      5'h0A: base = {{(XLEN-1){1'b0}}, a == b};
      default: base = '0;
    endcase
  end

  // ---- iteration steps ----
  // multiply: p = {acc_hi, multiplier}, shift right each step
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_nx;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mres;

  assign msum   = {1'b0, p[2*XLEN-1:XLEN]} +
                  (p[0] ? {1'b0, d} : '0);
  assign mul_nx = {msum, p[XLEN-1:1]};
  assign prod   = (nega ^ negb) ? -mul_nx : mul_nx;
  assign mres   = (mop == 3'd0) ? prod[XLEN-1:0]
                                : prod[2*XLEN-1:XLEN];

  // divide: p = {rem, quotient/dividend}, shift left each step
  logic [XLEN:0]     rs;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] div_nx;
  logic [XLEN-1:0]   q;
  logic [XLEN-1:0]   r;
  logic [XLEN-1:0]   dres;

  assign rs   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
  assign diff = rs - {1'b0, d};

  // borrow out means restore the shifted remainder
  assign div_nx = diff[XLEN]
    ? {rs[XLEN-1:0], p[XLEN-2:0], 1'b0}
    : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};

  assign q = div_nx[XLEN-1:0];
  assign r = div_nx[2*XLEN-1:XLEN];
  assign dres = mop[1] ? (nega ? -r : r)
                       : ((nega ^ negb) ? -q : q);

  // ---- control ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      d         <= '0;
      mop       <= '0;
      nega      <= 1'b0;
      negb      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_m) begin
              result    <= base;
              out_valid <= 1'b1;
              state     <= DONE;
            end else if (is_div && (bz || ovf)) begin
              result    <= fast;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              mop  <= m;
              nega <= sa;
              negb <= sb;
              cnt  <= '0;
              if (is_div) begin
                p     <= {{XLEN{1'b0}}, mag_a};
                d     <= mag_b;
                state <= DIV;
              end else begin
                p     <= {{XLEN{1'b0}}, mag_b};
                d     <= mag_a;
                state <= MUL;
              end
            end
          end
        end
        MUL: begin
          p <= mul_nx;
          if (cnt == LAST) begin
            result    <= mres;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          p <= div_nx;
          if (cnt == LAST) begin
            result    <= dres;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter (XLEN=32).
// Hand-computed vectors for base ops, mul/div, handshake and abort.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  int lat;

  alu_iter #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] va,
                       input logic [31:0] vb);
    alu_op   = op;
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    alu_op   = 5'h1F;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [4:0] op,
                     input logic [31:0] va, input logic [31:0] vb,
                     input logic [31:0] exp, input int exp_lat);
    int n;
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    issue(op, va, vb);
    wait_out(n);
    chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    chk(tag, result, exp);
    step();
    chk({tag, "_drop"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    alu_op    = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    run("add_wrap", 5'h00, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);
    run("sub", 5'h01, 32'd3, 32'd5, 32'hFFFF_FFFE, 1);
    run("sra", 5'h07, 32'h8000_0000, 32'h24, 32'hF800_0000, 1);
    run("srl", 5'h06, 32'h8000_0000, 32'h24, 32'h0800_0000, 1);
    run("sll", 5'h05, 32'h0000_0003, 32'h21, 32'h0000_0006, 1);
    run("slt", 5'h08, 32'hFFFF_FFFF, 32'd0, 32'd1, 1);
    run("sltu", 5'h09, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
    run("eq", 5'h0A, 32'd9, 32'd9, 32'd1, 1);
    run("xor", 5'h04, 32'hF0F0_1234, 32'h0FF0_1200, 32'hFF00_0034, 1);
    run("badop", 5'h0C, 32'd7, 32'd7, 32'd0, 1);

    run("mul", 5'h10, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run("mulh", 5'h11, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 33);
    run("mulhu", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 33);
    run("mulhsu", 5'h12, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFF, 33);
    run("mulh_mix", 5'h11, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 33);

    run("div", 5'h14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run("rem", 5'h16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run("divu", 5'h15, 32'd100, 32'd7, 32'd14, 33);
    run("remu", 5'h17, 32'd100, 32'd7, 32'd2, 33);
    run("div_neg_b", 5'h14, 32'd100, 32'hFFFF_FFF9,
        32'hFFFF_FFF2, 33);

    run("divu_z", 5'h15, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run("rem_z", 5'h16, 32'd5, 32'd0, 32'd5, 1);
    run("div_ovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    run("rem_ovf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // backpressure on a multiply
    out_ready = 1'b0;
    issue(5'h10, 32'd7, 32'hFFFF_FFFD);
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold", {result[29:0], out_valid, in_ready},
          {30'h3FFF_FFEB, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);

    // flush in cycle 10 of a divide; result must remain as before
    issue(5'h15, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_idle", {30'd0, out_valid, in_ready}, 32'b01);
    chk("flush_result", result, 32'hFFFF_FFEB);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) lat++;
      step();
    end
    chk("flush_novalid", 32'(lat), 32'd0);

    // in_valid alongside flush is not accepted
    alu_op   = 5'h00;
    a        = 32'd1;
    b        = 32'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("flush_noacc", {30'd0, out_valid, in_ready}, 32'b01);

    // async reset mid-multiply
    issue(5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    run("add_after", 5'h00, 32'd40, 32'd2, 32'd42, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
